// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
// Holds the FSM encoding, short simulation timers and ms->cycle conversion.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam int SIM_TRAVEL_CYC = 4;
    localparam int SIM_DOOR_CYC   = 3;

    function automatic logic [63:0] ms_to_cyc(
        input logic [63:0] clk_hz,
        input logic [63:0] ms
    );
        return clk_hz / 64'd1000 * ms;
    endfunction

endpackage

// File: rtl/elevator_call_scan.sv
// Combinational call scanner: which pending calls lie above, below or at
// the car's current floor, built from per-floor position masks.
module elevator_call_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic               any_above,
    output logic               any_below,
    output logic               hit_cur
);

    logic [FLOORS-1:0] above_mask;
    logic [FLOORS-1:0] below_mask;

    // Build position masks relative to the car and reduce against the calls
    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            above_mask[i] = (FLOOR_W'(i) > cur_floor);
            below_mask[i] = (FLOOR_W'(i) < cur_floor);
        end
        any_above = |(pending & above_mask);
        any_below = |(pending & below_mask);
        hit_cur   = |(pending & ~above_mask & ~below_mask);
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator car controller serving latched calls in SCAN order.
// Owns request capture, the travel/door down-counter and the car FSM.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 8,
    parameter bit SIMULATION = 1'b0,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TRAVEL_MS  = 1000,
    parameter int DOOR_MS    = 2000,
    localparam int FLOOR_W   = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] req_floor,
    input  logic               req_valid,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending,
    output logic               req_ack
);

    localparam logic [63:0] TRAVEL_CYC = SIMULATION ? 64'(SIM_TRAVEL_CYC)
                                       : ms_to_cyc(64'(CLK_HZ), 64'(TRAVEL_MS));
    localparam logic [63:0] DOOR_CYC   = SIMULATION ? 64'(SIM_DOOR_CYC)
                                       : ms_to_cyc(64'(CLK_HZ), 64'(DOOR_MS));
    localparam logic [63:0] TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int          TW   = $clog2(TMAX + 64'd1);
    localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_CYC);
    localparam logic [TW-1:0] D_LOAD = TW'(DOOR_CYC);
    localparam int          FS   = 1 << FLOOR_W;
    localparam logic [FS-1:0] FLOOR_OK = FS'((64'd1 << FLOORS) - 64'd1);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(FLOORS - 1);

    state_t             state, state_n;
    logic [FLOOR_W-1:0] cur_n, next_floor;
    logic               dir_n;
    logic [FLOORS-1:0]  pend_n, req_bit, clr_bit, merged;
    logic [TW-1:0]      timer, timer_n;
    logic               req_q;
    logic               rise, accept, serve_now, expire;
    logic               any_above, any_below, hit_cur;
    logic               ahead, behind;

    // A call for the car's own floor while stopped opens the door instead
    // of being latched; everything else in range lands in the bitmap.
    assign rise       = req_valid & ~req_q;
    assign accept     = rise & FLOOR_OK[req_floor];
    assign serve_now  = accept & (state != ST_MOVE) & (req_floor == cur_floor);
    assign expire     = (timer == TW'(1));
    assign next_floor = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
    assign merged     = pending | req_bit;
    assign ahead      = dir_up ? any_above : any_below;
    assign behind     = dir_up ? any_below : any_above;
    assign moving     = (state == ST_MOVE);
    assign door_open  = (state == ST_DOOR);

    elevator_call_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan (
        .pending   (pending),
        .cur_floor (cur_floor),
        .any_above (any_above),
        .any_below (any_below),
        .hit_cur   (hit_cur)
    );

    // One-hot of the accepted request, suppressed when served on the spot
    always_comb begin
        req_bit = '0;
        for (int i = 0; i < FLOORS; i++) begin
            req_bit[i] = accept & ~serve_now & (req_floor == FLOOR_W'(i));
        end
    end

    // Next-state, timer, direction and call-clear decisions
    always_comb begin
        state_n = state;
        cur_n   = cur_floor;
        dir_n   = dir_up;
        timer_n = (timer != '0) ? timer - TW'(1) : timer;
        clr_bit = '0;
        unique case (state)
            ST_IDLE: begin
                if (serve_now) begin
                    state_n = ST_DOOR;
                    timer_n = D_LOAD;
                end else if (any_above) begin
                    dir_n   = 1'b1;
                    state_n = ST_MOVE;
                    timer_n = T_LOAD;
                end else if (any_below) begin
                    dir_n   = 1'b0;
                    state_n = ST_MOVE;
                    timer_n = T_LOAD;
                end else if (hit_cur) begin
                    clr_bit = pending;
                    state_n = ST_DOOR;
                    timer_n = D_LOAD;
                end
            end
            ST_MOVE: begin
                if (expire) begin
                    cur_n = next_floor;
                    if (merged[next_floor]) begin
                        clr_bit[next_floor] = 1'b1;
                        state_n = ST_DOOR;
                        timer_n = D_LOAD;
                    end else begin
                        timer_n = T_LOAD;
                    end
                end
            end
            ST_DOOR: begin
                if (serve_now) begin
                    timer_n = D_LOAD;
                end else if (expire) begin
                    if (ahead) begin
                        state_n = ST_MOVE;
                        timer_n = T_LOAD;
                    end else if (behind) begin
                        dir_n   = ~dir_up;
                        state_n = ST_MOVE;
                        timer_n = T_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        pend_n = merged & ~clr_bit;
    end

    // Car state register; reset drops the car at floor 0 with no calls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur_floor <= '0;
            dir_up    <= 1'b1;
            pending   <= '0;
            timer     <= '0;
            req_q     <= 1'b0;
            req_ack   <= 1'b0;
        end else begin
            state     <= state_n;
            cur_floor <= cur_n;
            dir_up    <= dir_n;
            pending   <= pend_n;
            timer     <= timer_n;
            req_q     <= req_valid;
            req_ack   <= accept;
        end
    end

`ifndef SYNTHESIS
    // Direction choice must never step the car out of the shaft
    always @(posedge clk) begin
        if (!reset && state == ST_MOVE && expire) begin
            assert (dir_up ? (cur_floor != TOP) : (cur_floor != '0))
                else $error("car stepped past end of shaft at floor %0d", cur_floor);
        end
    end
`endif

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl at 8, 5 and 16 floors.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_elevator_scan_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_ack;

    logic [2:0] f8 = '0;
    logic       v8 = 1'b0;
    logic [2:0] cf8;
    logic       du8, mv8, do8, ack8;
    logic [7:0] pd8;

    logic [2:0] f5 = '0;
    logic       v5 = 1'b0;
    logic [2:0] cf5;
    logic       du5, mv5, do5, ack5;
    logic [4:0] pd5;

    logic [3:0]  f16 = '0;
    logic        v16 = 1'b0;
    logic [3:0]  cf16;
    logic        du16, mv16, do16, ack16;
    logic [15:0] pd16;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(.FLOORS(8), .SIMULATION(1'b1)) dut8 (
        .clk(clk), .reset(reset), .req_floor(f8), .req_valid(v8),
        .cur_floor(cf8), .dir_up(du8), .moving(mv8), .door_open(do8),
        .pending(pd8), .req_ack(ack8)
    );

    elevator_scan_ctrl #(.FLOORS(5), .SIMULATION(1'b1)) dut5 (
        .clk(clk), .reset(reset), .req_floor(f5), .req_valid(v5),
        .cur_floor(cf5), .dir_up(du5), .moving(mv5), .door_open(do5),
        .pending(pd5), .req_ack(ack5)
    );

    elevator_scan_ctrl #(.FLOORS(16), .SIMULATION(1'b1)) dut16 (
        .clk(clk), .reset(reset), .req_floor(f16), .req_valid(v16),
        .cur_floor(cf16), .dir_up(du16), .moving(mv16), .door_open(do16),
        .pending(pd16), .req_ack(ack16)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held for 5 cycles
        step(5);
        chk("rst_cur", 32'(cf8), 0);
        chk("rst_dir", 32'(du8), 1);
        chk("rst_mov", 32'(mv8), 0);
        chk("rst_door", 32'(do8), 0);
        chk("rst_pend", 32'(pd8), 0);
        chk("rst_ack", 32'(ack8), 0);
        reset = 1'b0;
        step(1);

        // single call to floor 3
        f8 = 3'd3; v8 = 1'b1;
        step(1);
        chk("s_ack", 32'(ack8), 1);
        chk("s_pend", 32'(pd8), 32'h08);
        chk("s_mov0", 32'(mv8), 0);
        v8 = 1'b0;
        step(1);
        chk("s_mov1", 32'(mv8), 1);
        chk("s_ack_off", 32'(ack8), 0);
        chk("s_cf0", 32'(cf8), 0);
        step(4);
        chk("s_cf1", 32'(cf8), 1);
        step(4);
        chk("s_cf2", 32'(cf8), 2);
        step(4);
        chk("s_cf3", 32'(cf8), 3);
        chk("s_door", 32'(do8), 1);
        chk("s_mov_off", 32'(mv8), 0);
        chk("s_pend_clr", 32'(pd8), 0);
        step(2);
        chk("s_door_last", 32'(do8), 1);
        step(1);
        chk("s_door_shut", 32'(do8), 0);
        chk("s_idle", 32'(mv8), 0);

        // reset in the middle of a move
        f8 = 3'd6; v8 = 1'b1;
        step(1);
        chk("r_pend", 32'(pd8), 32'h40);
        v8 = 1'b0;
        step(1);
        chk("r_mov", 32'(mv8), 1);
        step(2);
        #2 reset = 1'b1;
        #1;
        chk("ar_cur", 32'(cf8), 0);
        chk("ar_mov", 32'(mv8), 0);
        chk("ar_pend", 32'(pd8), 0);
        chk("ar_dir", 32'(du8), 1);
        chk("ar_door", 32'(do8), 0);
        @(negedge clk);
        reset = 1'b0;

        // SCAN: call 5, then 2 during the first hop
        f8 = 3'd5; v8 = 1'b1;
        step(1);
        v8 = 1'b0;
        step(1);
        chk("sc_mov", 32'(mv8), 1);
        f8 = 3'd2; v8 = 1'b1;
        step(1);
        chk("sc_pend2", 32'(pd8), 32'h24);
        v8 = 1'b0;
        step(7);
        chk("sc_cf2", 32'(cf8), 2);
        chk("sc_door2", 32'(do8), 1);
        chk("sc_pend5", 32'(pd8), 32'h20);
        step(3);
        chk("sc_resume", 32'(mv8), 1);
        chk("sc_door2_off", 32'(do8), 0);
        step(12);
        chk("sc_cf5", 32'(cf8), 5);
        chk("sc_door5", 32'(do8), 1);
        chk("sc_pend0", 32'(pd8), 0);
        step(3);
        chk("sc_idle5", 32'(mv8), 0);
        chk("sc_door5_off", 32'(do8), 0);
        chk("sc_dir5", 32'(du8), 1);

        // from 5: call 7, then 1 while heading up
        f8 = 3'd7; v8 = 1'b1;
        step(1);
        v8 = 1'b0;
        chk("sc_pend7", 32'(pd8), 32'h80);
        step(1);
        f8 = 3'd1; v8 = 1'b1;
        step(1);
        v8 = 1'b0;
        chk("sc_pend71", 32'(pd8), 32'h82);
        step(7);
        chk("sc_cf7", 32'(cf8), 7);
        chk("sc_door7", 32'(do8), 1);
        chk("sc_pend1", 32'(pd8), 32'h02);
        step(3);
        chk("sc_rev_dir", 32'(du8), 0);
        chk("sc_rev_mov", 32'(mv8), 1);
        step(24);
        chk("sc_cf1", 32'(cf8), 1);
        chk("sc_door1", 32'(do8), 1);
        chk("sc_pend_end", 32'(pd8), 0);
        chk("sc_dir1", 32'(du8), 0);
        step(3);

        // held request gives exactly one ack
        chk("h_idle", 32'(mv8), 0);
        f8 = 3'd4; v8 = 1'b1;
        step(1);
        chk("h_ack", 32'(ack8), 1);
        chk("h_pend", 32'(pd8), 32'h10);
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (ack8) n_ack++;
        end
        v8 = 1'b0;
        chk("h_extra_acks", 32'(n_ack), 0);
        chk("h_cf4", 32'(cf8), 4);
        chk("h_door_off", 32'(do8), 0);

        // call own floor: door opens, then restarts while open
        step(1);
        f8 = 3'd4; v8 = 1'b1;
        step(1);
        chk("o_ack", 32'(ack8), 1);
        chk("o_door", 32'(do8), 1);
        chk("o_pend", 32'(pd8), 0);
        v8 = 1'b0;
        step(2);
        v8 = 1'b1;
        step(1);
        chk("o_ack2", 32'(ack8), 1);
        chk("o_restart", 32'(do8), 1);
        chk("o_pend2", 32'(pd8), 0);
        v8 = 1'b0;
        step(2);
        chk("o_still_open", 32'(do8), 1);
        step(1);
        chk("o_closed", 32'(do8), 0);

        // FLOORS=5: out-of-range call, then top floor, then reverse
        f5 = 3'd6; v5 = 1'b1;
        step(1);
        chk("f5_no_ack", 32'(ack5), 0);
        chk("f5_pend_same", 32'(pd5), 0);
        v5 = 1'b0;
        step(1);
        f5 = 3'd4; v5 = 1'b1;
        step(1);
        chk("f5_ack", 32'(ack5), 1);
        chk("f5_pend", 32'(pd5), 32'h10);
        v5 = 1'b0;
        step(17);
        chk("f5_cf4", 32'(cf5), 4);
        chk("f5_door", 32'(do5), 1);
        chk("f5_pend0", 32'(pd5), 0);
        step(3);
        f5 = 3'd0; v5 = 1'b1;
        step(1);
        v5 = 1'b0;
        step(1);
        chk("f5_dir_down", 32'(du5), 0);
        chk("f5_mov", 32'(mv5), 1);

        // FLOORS=16: full-height run from 0 to 15
        f16 = 4'd15; v16 = 1'b1;
        step(1);
        chk("f16_ack", 32'(ack16), 1);
        chk("f16_pend", 32'(pd16), 32'h8000);
        v16 = 1'b0;
        step(60);
        chk("f16_cf14", 32'(cf16), 14);
        chk("f16_mov", 32'(mv16), 1);
        step(1);
        chk("f16_cf15", 32'(cf16), 15);
        chk("f16_door", 32'(do16), 1);
        chk("f16_pend0", 32'(pd16), 0);
        chk("f16_dir", 32'(du16), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
